ysyx_25030085_pc_gen: RTL
=========================

// Module: ysyx_25030085_pc_gen
// PURPOSE
//  Parametrised program-counter generator for the multi-cycle NPC core. Issues the current PC to
//  the IFU over a valid/ready handshake, waits for the EXU commit, then computes the next PC
//  (sequential, PC-relative, register-indirect, or trap/xret). Keeps a retired-instruction count.
// PARAMETERS
//  XLEN          32            PC/address width
//  RESET_VECTOR  32'h8000_0000 PC loaded on reset
//  TRAP_VECTOR   32'h8000_0100 redirect target on misaligned-target fault (macro build only)
//  CNT_W         64            retired-instruction counter width
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  fetch_valid    out  1     fetch_pc is a valid request to the IFU
//  fetch_ready    in   1     IFU accepts request this cycle
//  fetch_pc       out  XLEN  PC being fetched
//  commit_valid   in   1     EXU finished the outstanding instruction (1-cycle pulse)
//  commit_jump    in   2     00 seq, 01 pc+imm (jal/branch), 10 jalr, 11 trap/xret
//  commit_take    in   1     for 01 only: 1 = take pc+imm, 0 = pc+4 (jal drives 1)
//  commit_imm     in   XLEN  sign-extended immediate
//  commit_alu     in   XLEN  ALU result (jalr target before masking)
//  commit_tgt     in   XLEN  trap/xret target (mtvec/mepc) from CSR unit
//  pc_out         out  XLEN  architectural PC of the outstanding instruction
//  misalign_o     out  1     1-cycle pulse: computed target misaligned (0 unless macro set)
//  retire_cnt     out  CNT_W instructions retired since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_VECTOR, state=IDLE, fetch_valid=0, misalign_o=0, retire_cnt=0.
//  FSM IDLE -> FETCH: unconditional, one cycle after reset release (single bubble).
//  FETCH: fetch_valid=1, fetch_pc=pc; held stable until fetch_ready=1; on handshake -> EXEC.
//  EXEC: fetch_valid=0; wait for commit_valid; on commit: pc<=npc, retire_cnt++, -> FETCH.
//  Latency: commit at cycle N -> fetch_valid with new PC at N+1. Min loop = 2 cycles/instr.
//  npc: 00 pc+4; 01 take ? pc+imm : pc+4; 10 alu & ~1; 11 commit_tgt.
//  Arithmetic modulo 2^XLEN: pc=FFFF_FFFC, seq -> 0000_0000; no wrap flag.
//  retire_cnt wraps to 0 after all-ones; no saturation.
//  commit_valid while IDLE/FETCH: ignored, no state change (assertion flags it).
//  fetch_ready while not FETCH: ignored.
//  Reset asserted mid-handshake or in EXEC: immediate return to reset values; pending commit lost.
//  pc_out == fetch_pc at all times (equal in every state).
// CONFIGURATION
//  PC_MISALIGN_CHK_EN defined: on commit, if npc[1:0]!=0 then pc<=TRAP_VECTOR, misalign_o=1
//   for exactly the commit+1 cycle, retire_cnt still increments.
//  Not defined: npc used unchecked (jalr bit0 still cleared); misalign_o tied 0.
// STRUCTURE
//  Package ysyx_25030085_pc_pkg: jump_e (SEQ/REL/IND/TRAP), state_e (IDLE/FETCH/EXEC),
//   RESET_VECTOR/TRAP_VECTOR defaults.
//  Sub-module ysyx_25030085_npc_calc: combinational npc + misalign detect; top holds FSM,
//   PC register, counter.
// TESTING
//  Reset release, fetch_ready=1 -> IDLE 1 cyc, then fetch_valid=1, fetch_pc=8000_0000.
//  fetch_ready held 0 for 5 cyc -> fetch_valid stays 1, fetch_pc stable; ready=1 -> EXEC.
//  pc=8000_0010, jump=01 take=1 imm=FFFF_FFF0 -> next fetch_pc=8000_0000; take=0 -> 8000_0014.
//  jump=10 alu=8000_1233 -> fetch_pc=8000_1232 (macro on: misalign_o pulse, pc=TRAP_VECTOR).
//  jump=11 tgt=8000_0200; pc=FFFF_FFFC seq -> 0; commit_valid in FETCH -> no change.
//  100 commits then rst_n low in EXEC -> retire_cnt=100 before, 0 and pc=RESET_VECTOR at once.

Source files
------------

// File: rtl/ysyx_25030085_pc_pkg.sv
// Shared types and default vectors for the NPC program-counter generator.
package ysyx_25030085_pc_pkg;

  typedef enum logic [1:0] {
    SEQ  = 2'b00,
    REL  = 2'b01,
    IND  = 2'b10,
    TRAP = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h8000_0100;

endpackage

// File: rtl/ysyx_25030085_pc_gen_if.sv
// Fetch handshake and commit bundle between the PC generator, the IFU and the EXU.
interface ysyx_25030085_pc_gen_if #(
  parameter int XLEN = 32
);
  import ysyx_25030085_pc_pkg::*;

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            commit_valid;
  jump_e           commit_jump;
  logic            commit_take;
  logic [XLEN-1:0] commit_imm;
  logic [XLEN-1:0] commit_alu;
  logic [XLEN-1:0] commit_tgt;

  modport master (
    output fetch_valid, fetch_pc,
    input  fetch_ready,
    input  commit_valid, commit_jump, commit_take, commit_imm, commit_alu, commit_tgt
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    output fetch_ready,
    output commit_valid, commit_jump, commit_take, commit_imm, commit_alu, commit_tgt
  );

endinterface

// File: rtl/ysyx_25030085_npc_calc.sv
// Combinational next-PC selection and target alignment check.
// Macro PC_MISALIGN_CHK_EN enables the misaligned-target detect; otherwise misalign is 0.
module ysyx_25030085_npc_calc
  import ysyx_25030085_pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  jump_e           jump,
  input  logic            take,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] tgt,
  output logic [XLEN-1:0] npc,
  output logic            misalign
);

  always_comb begin
    npc = pc + XLEN'(4);
    case (jump)
      SEQ:  npc = pc + XLEN'(4);
      REL:  npc = take ? (pc + imm) : (pc + XLEN'(4));
      // jalr clears bit 0 of the ALU sum before it becomes a PC
      IND:  npc = alu & ~XLEN'(1);
      TRAP: npc = tgt;
      default: npc = pc + XLEN'(4);
    endcase
  end

`ifdef PC_MISALIGN_CHK_EN
  assign misalign = |npc[1:0];
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_25030085_pc_gen.sv
// Program-counter generator: IDLE/FETCH/EXEC loop, PC register, retired-instruction counter.
// Macro PC_MISALIGN_CHK_EN redirects misaligned targets to TRAP_VECTOR and pulses misalign_o.
module ysyx_25030085_pc_gen
  import ysyx_25030085_pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              CNT_W        = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_25030085_pc_gen_if.master  bus,
  output logic [XLEN-1:0]         pc_out,
  output logic                    misalign_o,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_EXEC  = EXEC;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic            misalign;

  ysyx_25030085_npc_calc #(.XLEN(XLEN)) u_npc_calc (
    .pc       (pc),
    .jump     (bus.commit_jump),
    .take     (bus.commit_take),
    .imm      (bus.commit_imm),
    .alu      (bus.commit_alu),
    .tgt      (bus.commit_tgt),
    .npc      (npc),
    .misalign (misalign)
  );

  assign bus.fetch_valid = (state == S_FETCH);
  assign bus.fetch_pc    = pc;
  assign pc_out          = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_VECTOR;
      retire_cnt <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (bus.fetch_ready) state <= S_EXEC;
        S_EXEC: begin
          if (bus.commit_valid) begin
            pc         <= misalign ? TRAP_VECTOR : npc;
            retire_cnt <= retire_cnt + CNT_W'(1);
            misalign_o <= misalign;
            state      <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A commit outside EXEC is flagged and must leave the architectural state untouched
  cover property (@(posedge clk) disable iff (!rst_n) bus.commit_valid && state != S_EXEC);

  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.commit_valid && state != S_EXEC) |=> ($stable(pc) && $stable(retire_cnt)))
    else $error("commit_valid outside EXEC altered pc/retire_cnt");

endmodule
